// File: rtl/counter_arbiter.sv
// Round-robin controller sharing one loadable up-counter among N requesters.
// Each granted requester gets the counter cleared and run up to its latched length.
module counter_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_len,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   done,
    output logic           busy,
    output logic [2:0]     owner,
    output logic           cnt_load,
    output logic [W-1:0]   cnt_data,
    output logic           cnt_en,
    input  logic [W-1:0]   cnt_out
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [3:0]   N4  = 4'(N);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t         state, state_nxt;
    logic [2:0]     ptr;
    logic [2:0]     ptr_nxt;
    logic [W-1:0]   len_q;
    logic [W-1:0]   len_sel;
    logic [3:0]     cand;
    logic [2:0]     sel;
    logic           found;

    // First pending requester scanning upward from ptr, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + k[3:0];
            if (cand >= N4) cand = cand - N4;
            if (!found && ((req & (ONE << cand)) != '0)) begin
                found = 1'b1;
                sel   = cand[2:0];
            end
        end
        ptr_nxt = (sel == 3'(N - 1)) ? '0 : sel + 3'd1;
        len_sel = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (sel == k[2:0]) len_sel = req_len[k*W +: W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            len_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && found) begin
                owner <= sel;
                ptr   <= ptr_nxt;
                len_q <= len_sel;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = '0;
        done      = '0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            IDLE: if (found) state_nxt = LOAD;
            LOAD: begin
                grant     = ONE << owner;
                cnt_load  = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (cnt_out == len_q) state_nxt = DONE;
                else                  cnt_en    = 1'b1;
            end
            DONE: begin
                done      = ONE << owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign cnt_data = '0;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: directed scenarios plus random requesters,
// checked every cycle against a service-timeline model of the arbiter.
module tb_counter_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_len;
    logic [N-1:0]   grant, done;
    logic           busy;
    logic [2:0]     owner;
    logic           cnt_load, cnt_en;
    logic [W-1:0]   cnt_data, cnt_out;

    counter_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len),
        .grant(grant), .done(done), .busy(busy), .owner(owner),
        .cnt_load(cnt_load), .cnt_data(cnt_data), .cnt_en(cnt_en),
        .cnt_out(cnt_out)
    );

    always #5 clk = ~clk;

    // Shared counter instance the arbiter drives.
    always @(posedge clk or posedge rst) begin
        if (rst)           cnt_out <= '0;
        else if (cnt_load) cnt_out <= cnt_data;
        else if (cnt_en)   cnt_out <= cnt_out + 1'b1;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model: each service is a timeline anchored at its grant cycle.
    int m_ptr = 0, m_owner = 0, m_len = 0;
    int g_cyc = -100, d_cyc = -100, free_at = -1;

    int last_grant = -1, last_done = -1, en_count = 0, max_cnt = 0;
    int gorder[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic decide();
        int i;
        if (rst || cyc != free_at) return;
        if (req == '0) begin
            free_at = cyc + 1;
            return;
        end
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (req[i]) break;
        end
        m_owner = i;
        m_len   = int'(req_len[i*W +: W]);
        m_ptr   = (i + 1) % N;
        g_cyc   = cyc + 1;
        d_cyc   = cyc + 3 + m_len;
        free_at = cyc + 4 + m_len;
    endtask

    task automatic compare();
        int eg, ed, eb, el, ee, eo;
        if (rst) begin
            eg = 0; ed = 0; eb = 0; el = 0; ee = 0; eo = 0;
        end else begin
            eg = (cyc == g_cyc) ? (1 << m_owner) : 0;
            ed = (cyc == d_cyc) ? (1 << m_owner) : 0;
            eb = (cyc >= g_cyc && cyc <= d_cyc) ? 1 : 0;
            el = (cyc == g_cyc) ? 1 : 0;
            ee = (cyc >= g_cyc + 1 && cyc <= g_cyc + m_len) ? 1 : 0;
            eo = m_owner;
        end
        check("grant", int'(grant), eg);
        check("done", int'(done), ed);
        check("busy", int'(busy), eb);
        check("cnt_load", int'(cnt_load), el);
        check("cnt_en", int'(cnt_en), ee);
        check("owner", int'(owner), eo);
        check("cnt_data", int'(cnt_data), 0);
        if (!rst && cyc >= g_cyc + 1 && cyc <= g_cyc + 1 + m_len)
            check("cnt_out", int'(cnt_out), cyc - g_cyc - 1);
        if (grant != '0) begin
            last_grant = cyc;
            for (int i = 0; i < N; i++) if (grant[i]) gorder.push_back(i);
        end
        if (done != '0) last_done = cyc;
        if (cnt_en) en_count++;
        if (int'(cnt_out) > max_cnt) max_cnt = int'(cnt_out);
    endtask

    task automatic step();
        decide();
        @(posedge clk);
        cyc++;
        #2;
        compare();
    endtask

    task automatic assert_rst();
        rst     = 1'b1;
        m_ptr   = 0;
        m_owner = 0;
        m_len   = 0;
        g_cyc   = -100;
        d_cyc   = -100;
        free_at = -1;
    endtask

    // The cycle in which reset drops is an IDLE cycle that samples req.
    task automatic release_rst();
        rst     = 1'b0;
        free_at = cyc;
    endtask

    task automatic set_len(input int i, input int v);
        req_len[i*W +: W] = W'(v);
    endtask

    task automatic wait_pulse(input string tag, input bit on_done, input int who, input int budget);
        logic [N-1:0] v;
        int hit;
        hit = 0;
        for (int k = 0; k < budget; k++) begin
            step();
            v = on_done ? done : grant;
            if (v[who]) begin
                hit = 1;
                break;
            end
        end
        check(tag, hit, 1);
    endtask

    task automatic wait_any_grant(input string tag, input int budget, output int idx);
        int hit;
        hit = 0;
        idx = -1;
        for (int k = 0; k < budget; k++) begin
            step();
            if (grant != '0) begin
                hit = 1;
                for (int i = 0; i < N; i++) if (grant[i]) idx = i;
                break;
            end
        end
        check(tag, hit, 1);
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    int idx;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        // Reset with random requests present.
        assert_rst();
        req     = N'($urandom);
        req_len = {N{W'($urandom)}};
        drain(3);
        req = '0;
        release_rst();
        drain(3);

        // Single request, length 5.
        set_len(0, 5);
        req = 4'b0001;
        en_count = 0;
        wait_pulse("single_grant", 1'b0, 0, 10);
        req = '0;
        wait_pulse("single_done", 1'b1, 0, 20);
        check("single_latency", last_done - last_grant, 7);
        check("single_en_cycles", en_count, 5);
        drain(3);

        // Round-robin from ptr=0 with all requesters held.
        assert_rst();
        drain(2);
        release_rst();
        set_len(0, 1); set_len(1, 2); set_len(2, 3); set_len(3, 4);
        gorder.delete();
        req = 4'b1111;
        for (int k = 0; k < 100 && gorder.size() < 5; k++) step();
        req = '0;
        check("rr_count", gorder.size(), 5);
        for (int i = 0; i < 5 && i < gorder.size(); i++) check("rr_order", gorder[i], exp_order[i]);
        drain(10);

        // Pointer wrap: after serving 3, requester 0 wins over 3.
        set_len(3, 2);
        req = 4'b1000;
        wait_pulse("wrap_g3", 1'b0, 3, 10);
        req = '0;
        wait_pulse("wrap_d3", 1'b1, 3, 10);
        set_len(0, 1);
        req = 4'b1001;
        wait_any_grant("wrap_first", 10, idx);
        check("wrap_first_idx", idx, 0);
        req = 4'b1000;
        wait_pulse("wrap_second", 1'b0, 3, 20);
        req = '0;
        drain(8);

        // Zero length.
        set_len(1, 0);
        req = 4'b0010;
        en_count = 0;
        wait_pulse("len0_grant", 1'b0, 1, 10);
        req = '0;
        wait_pulse("len0_done", 1'b1, 1, 10);
        check("len0_latency", last_done - last_grant, 2);
        check("len0_en", en_count, 0);
        drain(2);

        // Maximum length: counter reaches 255 without wrapping.
        set_len(2, 255);
        req = 4'b0100;
        max_cnt = 0;
        wait_pulse("len255_grant", 1'b0, 2, 10);
        req = '0;
        wait_pulse("len255_done", 1'b1, 2, 300);
        check("len255_latency", last_done - last_grant, 257);
        check("len255_max", max_cnt, 255);
        drain(2);

        // Reset in the middle of an interval, then restart from ptr=0.
        set_len(1, 10);
        set_len(3, 1);
        req = 4'b0010;
        wait_pulse("mid_grant", 1'b0, 1, 10);
        req = 4'b1010;
        for (int k = 0; k < 10 && cyc != g_cyc + 4; k++) step();
        check("mid_cnt3", int'(cnt_out), 3);
        assert_rst();
        #1;
        compare();
        drain(2);
        release_rst();
        wait_any_grant("post_rst_grant", 10, idx);
        check("post_rst_idx", idx, 1);
        req = 4'b1000;
        wait_pulse("post_rst_g3", 1'b0, 3, 30);
        req = '0;
        drain(6);

        // Random requesters: hold req/len until granted, then drop or re-request.
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (cyc == g_cyc && m_owner == i) begin
                    if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                    else set_len(i, ($urandom_range(15, 0) == 0) ? $urandom_range(255, 0) : $urandom_range(11, 0));
                end else if (!req[i]) begin
                    if ($urandom_range(7, 0) == 0) begin
                        req[i] = 1'b1;
                        set_len(i, ($urandom_range(15, 0) == 0) ? $urandom_range(255, 0) : $urandom_range(11, 0));
                    end
                end else if ($urandom_range(63, 0) == 0) begin
                    req[i] = 1'b0;
                end
            end
            step();
        end
        req = '0;
        drain(300);
        check("final_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
